// File: rtl/frame_writer.sv
// -----------------------------------------------------------------------------
// frame_writer
//   Writer side of the dual-address frame BRAM. Converts a raster pixel stream
//   (start-of-frame / end-of-line marked) into BRAM write-port cycles. It
//   checks the frame geometry and pulses frame_done on the last pixel. It
//   raises a sticky err on malformed frames. Capture is single-shot (arm) or
//   continuous.
//
// Ports
//   clk        : system clock, all logic on posedge
//   rst_n      : asynchronous active-low reset
//   arm        : pulse, capture the next complete frame (ignored while busy)
//   continuous : level, capture every frame while high
//   clr_err    : pulse, clear sticky err
//   pix_valid  : pix_data valid this cycle
//   pix_sof    : with pix_valid, first pixel of a frame
//   pix_eol    : with pix_valid, last pixel of a line
//   pix_data   : pixel value
//   we         : BRAM write enable (registered, 1 cycle after the pixel)
//   wr_addr    : BRAM write address
//   din        : BRAM write data
//   busy       : high while a frame is being captured
//   frame_done : 1-cycle pulse alongside the write of the frame's last pixel
//   err        : sticky geometry error
// -----------------------------------------------------------------------------
module frame_writer #(
  parameter int LOGSIZE  = 16,
  parameter int WIDTH    = 24,
  parameter int H_PIXELS = 256,
  parameter int V_LINES  = 192
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arm,
  input  logic               continuous,
  input  logic               clr_err,
  input  logic               pix_valid,
  input  logic               pix_sof,
  input  logic               pix_eol,
  input  logic [WIDTH-1:0]   pix_data,
  output logic               we,
  output logic [LOGSIZE-1:0] wr_addr,
  output logic [WIDTH-1:0]   din,
  output logic               busy,
  output logic               frame_done,
  output logic               err
);

  localparam int XW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int YW = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_PIXELS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_LINES - 1);

  typedef enum logic {IDLE, CAPTURE} state_t;

  state_t             state;
  logic [XW-1:0]      x;
  logic [YW-1:0]      y;
  logic [LOGSIZE-1:0] addr;   // address of the next in-frame pixel (y*H+x)
  logic               armed;

  logic start;
  logic cap;
  logic x_last;
  logic err_set;

  always_comb begin
    start  = (state == IDLE) && pix_valid && pix_sof && (armed || continuous);
    cap    = (state == CAPTURE) && pix_valid;
    x_last = (x == X_LAST);
    // A restart sof, or an eol that disagrees with the column position
    // (short or long line), marks the frame as malformed.
    err_set = cap && (pix_sof || (x_last != pix_eol));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      addr       <= '0;
      armed      <= 1'b0;
      we         <= 1'b0;
      wr_addr    <= '0;
      din        <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      we         <= 1'b0;
      frame_done <= 1'b0;

      // Set wins over a simultaneous clear.
      if (err_set)      err <= 1'b1;
      else if (clr_err) err <= 1'b0;

      if (arm && !busy) armed <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            we      <= 1'b1;
            wr_addr <= '0;
            din     <= pix_data;
            x       <= XW'(1);
            y       <= '0;
            addr    <= LOGSIZE'(1);
            armed   <= 1'b0;      // overrides a same-cycle arm
            busy    <= 1'b1;
            state   <= CAPTURE;
          end
        end

        CAPTURE: begin
          if (pix_valid) begin
            we  <= 1'b1;
            din <= pix_data;
            if (pix_sof) begin
              // Restart: this pixel becomes pixel 0 of a fresh frame.
              wr_addr <= '0;
              x       <= XW'(1);
              y       <= '0;
              addr    <= LOGSIZE'(1);
            end else begin
              wr_addr <= addr;
              if (x_last && pix_eol) begin
                if (y == Y_LAST) begin
                  frame_done <= 1'b1;
                  busy       <= 1'b0;
                  state      <= IDLE;
                end else begin
                  x    <= '0;
                  y    <= y + YW'(1);
                  addr <= addr + LOGSIZE'(1);
                end
              end else if (x_last || pix_eol) begin
                // Geometry broken: keep the pixel, abandon the frame.
                busy  <= 1'b0;
                state <= IDLE;
              end else begin
                x    <= x + XW'(1);
                addr <= addr + LOGSIZE'(1);
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_writer.sv
// -----------------------------------------------------------------------------
// tb_frame_writer
//   Self-checking bench for frame_writer with a 4x2 frame. Vector tables hold
//   per-cycle stimulus plus the expected write and busy level. Expected writes
//   go to a scoreboard queue when driven, and a negedge monitor pops and
//   compares them against the DUT write port.
// -----------------------------------------------------------------------------
module tb_frame_writer;

  localparam int LOGSIZE = 4;
  localparam int WIDTH   = 8;
  localparam int HP      = 4;
  localparam int VL      = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n, arm, continuous, clr_err;
  logic               pix_valid, pix_sof, pix_eol;
  logic [WIDTH-1:0]   pix_data;
  logic               we;
  logic [LOGSIZE-1:0] wr_addr;
  logic [WIDTH-1:0]   din;
  logic               busy, frame_done, err;

  frame_writer #(
    .LOGSIZE (LOGSIZE),
    .WIDTH   (WIDTH),
    .H_PIXELS(HP),
    .V_LINES (VL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .arm       (arm),
    .continuous(continuous),
    .clr_err   (clr_err),
    .pix_valid (pix_valid),
    .pix_sof   (pix_sof),
    .pix_eol   (pix_eol),
    .pix_data  (pix_data),
    .we        (we),
    .wr_addr   (wr_addr),
    .din       (din),
    .busy      (busy),
    .frame_done(frame_done),
    .err       (err)
  );

  typedef struct {
    bit         v;
    bit         sof;
    bit         eol;
    bit         clr;
    logic [7:0] data;
    bit         w;      // a write is expected for this pixel
    int         addr;
    bit         done;
    bit         eb;     // busy expected after this cycle
  } vec_t;

  typedef struct {
    int addr;
    int data;
    bit done;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Write-port monitor.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (we) begin
        if (sb.size() == 0) begin
          chk("unexpected_we", int'(we), 0);
        end else begin
          e = sb.pop_front();
          chk("wr_addr", int'(wr_addr), e.addr);
          chk("din", int'(din), e.data);
          chk("frame_done", int'(frame_done), int'(e.done));
        end
      end else if (frame_done) begin
        chk("done_without_we", int'(frame_done), 0);
      end
    end
  end

  function automatic void add(bit v, bit sof, bit eol, bit clr, int data,
                              bit w, int addr, bit done, bit eb);
    vec_t r;
    r.v = v; r.sof = sof; r.eol = eol; r.clr = clr;
    r.data = data[7:0]; r.w = w; r.addr = addr; r.done = done; r.eb = eb;
    tbl.push_back(r);
  endfunction

  // One full 4x2 frame starting at data value base, with gap idle cycles
  // after each pixel; wr selects whether it is expected to be captured.
  function automatic void add_frame(int base, int gap, bit wr);
    for (int i = 0; i < HP*VL; i++) begin
      bit last;
      last = (i == HP*VL-1);
      add(1'b1, i == 0, (i % HP) == HP-1, 1'b0, base + i, wr, i, last, wr && !last);
      for (int g = 0; g < gap; g++)
        add(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, wr && !last);
    end
  endfunction

  task automatic run(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      pix_valid = tbl[i].v;
      pix_sof   = tbl[i].sof;
      pix_eol   = tbl[i].eol;
      clr_err   = tbl[i].clr;
      pix_data  = tbl[i].data[WIDTH-1:0];
      if (tbl[i].w) begin
        exp_t e;
        e.addr = tbl[i].addr;
        e.data = int'(tbl[i].data);
        e.done = tbl[i].done;
        sb.push_back(e);
      end
      @(posedge clk); #1;
      chk({tag, "_busy"}, int'(busy), int'(tbl[i].eb));
    end
    pix_valid = 1'b0; pix_sof = 1'b0; pix_eol = 1'b0; clr_err = 1'b0;
    tbl.delete();
    @(negedge clk); #1;
    chk({tag, "_sb_drain"}, sb.size(), 0);
    sb.delete();
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
  endtask

  task automatic pulse_clr(input string tag);
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    chk({tag, "_err_cleared"}, int'(err), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; arm = 1'b0; continuous = 1'b0; clr_err = 1'b0;
    pix_valid = 1'b0; pix_sof = 1'b0; pix_eol = 1'b0; pix_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", int'(we), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_din", int'(din), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_err", int'(err), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-shot capture of one clean frame.
    pulse_arm();
    add_frame(8'h10, 0, 1'b1);
    run("t1");
    chk("t1_err", int'(err), 0);

    // Not armed, not continuous: the frame is dropped (armed was consumed).
    add_frame(8'h18, 0, 1'b0);
    run("t2");

    // Continuous, two frames with 2-cycle valid gaps.
    continuous = 1'b1;
    add_frame(8'h20, 2, 1'b1);
    add_frame(8'h30, 2, 1'b1);
    run("t3");
    chk("t3_err", int'(err), 0);
    continuous = 1'b0;

    // Short line: eol on the 3rd pixel; the next pixel is dropped.
    pulse_arm();
    add(1, 1, 0, 0, 8'h40, 1, 0, 0, 1);
    add(1, 0, 0, 0, 8'h41, 1, 1, 0, 1);
    add(1, 0, 1, 0, 8'h42, 1, 2, 0, 0);
    add(1, 0, 0, 0, 8'h43, 0, 0, 0, 0);
    run("t4");
    chk("t4_err", int'(err), 1);
    pulse_clr("t4");

    // Long line: last column without eol.
    pulse_arm();
    add(1, 1, 0, 0, 8'h48, 1, 0, 0, 1);
    add(1, 0, 0, 0, 8'h49, 1, 1, 0, 1);
    add(1, 0, 0, 0, 8'h4A, 1, 2, 0, 1);
    add(1, 0, 0, 0, 8'h4B, 1, 3, 0, 0);
    run("t4b");
    chk("t4b_err", int'(err), 1);
    pulse_clr("t4b");

    // sof at the 6th pixel restarts at address 0; clr_err in that same
    // cycle must not win over the new error.
    pulse_arm();
    for (int i = 0; i < 5; i++)
      add(1, i == 0, i == 3, 0, 8'h50 + i, 1, i, 0, 1);
    add(1, 1, 0, 1, 8'h55, 1, 0, 0, 1);
    for (int j = 1; j < 8; j++)
      add(1, 0, (j == 3) || (j == 7), 0, 8'h55 + j, 1, j, j == 7, j != 7);
    run("t5");
    chk("t5_err_set_wins", int'(err), 1);
    pulse_clr("t5");

    // Asynchronous reset mid-frame, then a clean continuous frame.
    continuous = 1'b1;
    for (int i = 0; i < 5; i++)
      add(1, i == 0, i == 3, 0, 8'h60 + i, 1, i, 0, 1);
    run("t6a");
    rst_n = 1'b0;
    #1;
    chk("t6_rst_we", int'(we), 0);
    chk("t6_rst_wr_addr", int'(wr_addr), 0);
    chk("t6_rst_din", int'(din), 0);
    chk("t6_rst_busy", int'(busy), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    add(1, 0, 0, 0, 8'h65, 0, 0, 0, 0);
    add(1, 0, 0, 0, 8'h66, 0, 0, 0, 0);
    add(1, 0, 1, 0, 8'h67, 0, 0, 0, 0);
    add_frame(8'h70, 0, 1'b1);
    run("t6b");
    chk("t6_err", int'(err), 0);
    continuous = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
